// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// one-hot FSM encoding, requester ids and read-return tag layout.
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam int ST_IDLE    = 0;
    localparam int ST_CPU_OWN = 1;
    localparam int ST_DMA_OWN = 2;
    localparam int ST_TURN_C  = 3;
    localparam int ST_TURN_D  = 4;
    localparam int STATE_W    = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = STATE_W'(1 << ST_IDLE),
        CPU_OWN = STATE_W'(1 << ST_CPU_OWN),
        DMA_OWN = STATE_W'(1 << ST_DMA_OWN),
        TURN_C  = STATE_W'(1 << ST_TURN_C),
        TURN_D  = STATE_W'(1 << ST_TURN_D)
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    localparam int TAG_W = $bits(rd_tag_t);

    function automatic rd_tag_t make_tag(input logic valid, input logic port);
        rd_tag_t t;
        t.valid = valid;
        t.port  = port;
        return t;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters plus memory macro.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_gnt;
    logic              cpu_rd_valid;
    logic [DATA_W-1:0] cpu_rd_data;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wr_data;
    logic              dma_gnt;
    logic              dma_rd_valid;
    logic [DATA_W-1:0] dma_rd_data;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wr_data,
        output cpu_gnt, cpu_rd_valid, cpu_rd_data,
        input  dma_req, dma_we, dma_addr, dma_wr_data,
        output dma_gnt, dma_rd_valid, dma_rd_data,
        output mem_en, mem_we, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wr_data,
        input  cpu_gnt, cpu_rd_valid, cpu_rd_data,
        output dma_req, dma_we, dma_addr, dma_wr_data,
        input  dma_gnt, dma_rd_valid, dma_rd_data,
        input  mem_en, mem_we, mem_addr, mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/mem_arbiter_rd_tag_pipe.sv
// Delay line of {valid, port} read tags, aligned to the memory read latency
// so the returning data can be steered to the requester that issued it.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single synchronous memory port with
// turnaround cycles on handover and bounded starvation in both directions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned DMA_MAX_WAIT  = 8,
    parameter int unsigned DMA_BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned WAIT_W  = $clog2(DMA_MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(DMA_BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(DMA_MAX_WAIT);
    localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(DMA_MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(DMA_BURST_MAX);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_BURST_MAX - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0]   cpu_rd_q, dma_rd_q;
    logic                cpu_gnt, dma_gnt;
    logic                cpu_ret, dma_ret;
    rd_tag_t             tag_in, tag_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            cpu_rd_q    <= '0;
            dma_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            if (cpu_ret) cpu_rd_q <= bus.mem_rd_data;
            if (dma_ret) dma_rd_q <= bus.mem_rd_data;
        end
    end

    // Counters default to zero so they clear whenever the owning state is left.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req)      state_d = CPU_OWN;
                else if (bus.dma_req) state_d = DMA_OWN;
            end
            CPU_OWN: begin
                cpu_gnt = bus.cpu_req;
                if (bus.dma_req && (!bus.cpu_req || wait_cnt_q == WAIT_LAST)) begin
                    state_d = TURN_D;
                end else if (!bus.cpu_req && !bus.dma_req) begin
                    state_d = IDLE;
                end else if (bus.dma_req) begin
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
                end
            end
            DMA_OWN: begin
                dma_gnt     = bus.dma_req;
                burst_cnt_d = burst_cnt_q;
                if (bus.cpu_req && (!bus.dma_req || (dma_gnt && burst_cnt_q == BURST_LAST))) begin
                    state_d     = TURN_C;
                    burst_cnt_d = '0;
                end else if (!bus.cpu_req && !bus.dma_req) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end else if (dma_gnt && bus.cpu_req && burst_cnt_q != BURST_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            TURN_C:  state_d = CPU_OWN;
            TURN_D:  state_d = DMA_OWN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        if (cpu_gnt) begin
            bus.mem_en      = 1'b1;
            bus.mem_we      = bus.cpu_we;
            bus.mem_addr    = bus.cpu_addr;
            bus.mem_wr_data = bus.cpu_wr_data;
        end else if (dma_gnt) begin
            bus.mem_en      = 1'b1;
            bus.mem_we      = bus.dma_we;
            bus.mem_addr    = bus.dma_addr;
            bus.mem_wr_data = bus.dma_wr_data;
        end
    end

    assign tag_in = make_tag((cpu_gnt && !bus.cpu_we) || (dma_gnt && !bus.dma_we),
                             dma_gnt ? PORT_DMA : PORT_CPU);

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Returning data is passed through live on its tag cycle and held afterwards.
    assign cpu_ret = tag_out.valid && (tag_out.port == PORT_CPU);
    assign dma_ret = tag_out.valid && (tag_out.port == PORT_DMA);

    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.dma_gnt      = dma_gnt;
    assign bus.cpu_rd_valid = cpu_ret;
    assign bus.dma_rd_valid = dma_ret;
    assign bus.cpu_rd_data  = cpu_ret ? bus.mem_rd_data : cpu_rd_q;
    assign bus.dma_rd_data  = dma_ret ? bus.mem_rd_data : dma_rd_q;

endmodule
